// File: rtl/decoder_stream_if.sv
// Command/beat bundle for decoder_stream: command side (valid/ready + payload)
// and decoded output side (valid/ready + scan status).
interface decoder_stream_if #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 8
);
  localparam int OUT_W = 1 << SEL_W;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic [1:0]       mode;
  logic [DIV_W-1:0] scan_period;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             scanning;

  modport master (
    output in_valid, sel, mode, scan_period, out_ready,
    input  in_ready, out, out_valid, scanning
  );

  modport slave (
    input  in_valid, sel, mode, scan_period, out_ready,
    output in_ready, out, out_valid, scanning
  );
endinterface

// File: rtl/decoder_stream.sv
// Registered SEL_W-to-2^SEL_W decoder with valid/ready on both sides.
// Modes: one-hot, thermometer, inverted one-hot, and a free-running scan strobe.
module decoder_stream #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 8
) (
  input logic              clk,
  input logic              reset,
  decoder_stream_if.slave  io_bus
);
  localparam int OUT_W = 1 << SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SCAN
  } state_t;

  state_t           r_state;
  logic [OUT_W-1:0] r_out;
  logic             r_out_valid;
  logic             r_scanning;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_period;
  logic [SEL_W-1:0] r_pos;

  logic             w_in_ready;
  logic             w_accept;
  logic [OUT_W-1:0] w_onehot;
  logic [OUT_W-1:0] w_therm;
  logic [OUT_W-1:0] w_decoded;
  logic [SEL_W-1:0] w_pos_next;
  logic [OUT_W-1:0] w_scan_next;

  // HOLD is the only state that can stall; it frees up the cycle the beat is consumed.
  assign w_in_ready = (r_state == ST_HOLD) ? io_bus.out_ready : 1'b1;
  assign w_accept   = io_bus.in_valid && w_in_ready;
  assign w_pos_next = r_pos + SEL_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_bits
      assign w_onehot[gi]    = (io_bus.sel == SEL_W'(gi));
      assign w_therm[gi]     = (io_bus.sel >= SEL_W'(gi));
      assign w_scan_next[gi] = (w_pos_next == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    w_decoded = w_onehot;
    case (io_bus.mode)
      2'b01:   w_decoded = w_therm;
      2'b10:   w_decoded = ~w_onehot;
      default: w_decoded = w_onehot;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_scanning  <= 1'b0;
      r_div       <= '0;
      r_period    <= '0;
      r_pos       <= '0;
    end else if (w_accept) begin
      r_out       <= w_decoded;
      r_out_valid <= 1'b1;
      if (io_bus.mode == 2'b11) begin
        r_state    <= ST_SCAN;
        r_scanning <= 1'b1;
        r_pos      <= io_bus.sel;
        r_div      <= '0;
        r_period   <= io_bus.scan_period;
      end else begin
        r_state    <= ST_HOLD;
        r_scanning <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_HOLD: begin
          // out keeps its last value after consumption; only valid drops.
          if (io_bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (r_div == r_period) begin
            r_div <= '0;
            r_pos <= w_pos_next;
            r_out <= w_scan_next;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out       = r_out;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.scanning  = r_scanning;
endmodule

// File: doc/decoder_stream.md
Name: decoder_stream

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W decoder with a valid/ready handshake on both the input and output sides.
- Supports four output modes: one-hot, thermometer, active-low one-hot, and self-timed scan.
- Scan mode walks a one-hot bit across the output and drives LED/row-select style strobes in the lab datapath.

Parameters:
- SEL_W, 3, select width; OUT_W = 2**SEL_W is derived locally and cannot be overridden.
- DIV_W, 8, width of the scan period divider.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  a command is presented on sel/mode.
- in_ready  output  1  block can accept a command this cycle.
- sel  input  SEL_W  select index, or scan start position.
- mode  input  2  00 one-hot, 01 thermometer, 10 active-low one-hot, 11 scan.
- scan_period  input  DIV_W  scan dwell is scan_period+1 cycles; sampled on command accept.
- out  output  OUT_W  registered decoded value.
- out_valid  output  1  out holds a valid beat.
- out_ready  input  1  downstream consumes the beat.
- scanning  output  1  high while in SCAN state.

Behaviour:
- Reset (async assert, sync release): out=0, out_valid=0, scanning=0, state=IDLE, divider=0, scan position=0. Reset mid-scan or mid-hold aborts immediately; out returns to 0 (all-zero even for mode 10).
- Command accepted when in_valid && in_ready. Decoded result appears on out with out_valid=1 on the next rising edge (latency 1).
- Decode rules, with s = sel:
  - 00: out[s]=1, all other bits 0.
  - 01: out[i]=1 for all i<=s; s=OUT_W-1 gives all ones.
  - 10: bitwise inverse of the one-hot value.
  - 11: out = one-hot(s), and the block enters SCAN.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - HOLD: out_valid=1. in_ready=out_ready, so a beat can be replaced in the same cycle it is consumed. If out_ready=1 with no new command, go to IDLE and clear out_valid; out keeps its last value. If out_ready=0, out and out_valid stay stable and the input is stalled.
  - SCAN: out_valid=1, scanning=1, in_ready=1. out_ready is ignored; scan is a free-running strobe. The divider counts 0..scan_period. When it reaches scan_period it resets to 0 and the position advances by 1. The position wraps from OUT_W-1 to 0. With scan_period=0 the position advances every cycle.
- Transitions from SCAN:
  - A new non-scan command goes to HOLD with the new value next cycle.
  - A new scan command restarts at the new sel with the divider cleared and the new period latched.
- Simultaneous events: accept and consume in HOLD in the same cycle loads the new beat, so out_valid stays 1 with no bubble. in_valid while in_ready=0 is ignored; the source must hold its command.
- sel/mode/scan_period are only sampled on accept; changes at other times have no effect.

Test Plan:
- Reset then mode=00, sel=5, in_valid for 1 cycle, out_ready=1 -> next cycle out=8'h20, out_valid=1. Following cycle out_valid=0, out stays 8'h20.
- mode=01, sel=3 -> out=8'h0F. sel=7 -> out=8'hFF. mode=10, sel=0 -> out=8'hFE.
- Backpressure: out_ready=0, send sel=2 then present sel=6 -> in_ready=0, out stays 8'h04 for 5 cycles. Raise out_ready -> sel=6 accepted, out=8'h40 next cycle, no bubble.
- Scan: mode=11, sel=6, scan_period=2 -> out sequence is 8'h40 for 3 cycles, then 8'h80 for 3 cycles, then wraps to 8'h01; scanning=1 throughout, independent of out_ready=0.
- Scan exit: during scan, command mode=00, sel=1 -> next cycle out=8'h02, scanning=0, state HOLD.
- Async reset asserted mid-scan between clock edges -> out=0, out_valid=0, scanning=0 immediately. After release, no output until a new command is accepted.
